// File: rtl/matmul_ctrl_p.sv
// N x N matrix-multiply controller: streams row i of A and column j of B out of
// single-port register files, accumulates N products, and writes C[i][j].
module matmul_ctrl_p #(
    parameter int N  = 64,
    parameter int DW = 8,
    parameter int AW = $clog2(N*N),
    parameter int CW = 2*DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          signed_mode,
    output logic          busy,
    output logic          done,
    output logic          nce_a,
    output logic [AW-1:0] addr_a,
    input  logic [DW-1:0] do_a,
    output logic          nce_b,
    output logic [AW-1:0] addr_b,
    input  logic [DW-1:0] do_b,
    output logic          nce_c,
    output logic          nwrt_c,
    output logic [AW-1:0] addr_c,
    output logic [CW-1:0] din_c
);

    localparam int LW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] i;
    logic [LW-1:0] j;
    logic [LW-1:0] k;
    logic [CW-1:0] acc;
    logic          sgn;
    logic [AW-1:0] addr_c_r;
    logic [CW-1:0] din_c_r;
    logic          last_k;
    logic          last_j;
    logic          last_elem;
    logic [CW-1:0] acc_sum;

    // DW x DW product widened to the accumulator width; zero- or sign-extended.
    function automatic logic [CW-1:0] prod(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic          s);
        logic signed [2*DW-1:0] ps;
        logic        [2*DW-1:0] pu;
        ps = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
        pu = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        if (s)
            return {{(CW-2*DW){ps[2*DW-1]}}, ps};
        else
            return {{(CW-2*DW){1'b0}}, pu};
    endfunction

    assign last_k    = (k == LW'(N-1));
    assign last_j    = (j == LW'(N-1));
    assign last_elem = last_j && (i == LW'(N-1));
    assign acc_sum   = acc + prod(do_a, do_b, sgn);

    // N is a power of two, so i*N+k etc. are plain concatenations.
    assign addr_a = {i, k};
    assign addr_b = {k, j};
    assign addr_c = addr_c_r;
    assign din_c  = din_c_r;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        nce_a     = 1'b1;
        nce_b     = 1'b1;
        nce_c     = 1'b1;
        nwrt_c    = 1'b1;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                busy  = 1'b1;
                nce_a = 1'b0;
                nce_b = 1'b0;
                if (abort)
                    state_nxt = S_IDLE;
                else if (last_k)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort)
                    state_nxt = S_IDLE;
                else
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                // An abort in the write cycle kills the strobe itself.
                nce_c  = abort;
                nwrt_c = abort;
                if (abort)
                    state_nxt = S_IDLE;
                else if (last_elem)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_RUN;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            sgn      <= 1'b0;
            addr_c_r <= '0;
            din_c_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        sgn <= signed_mode;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end else begin
                        // Read data lags the address by one cycle, so k=0 sees stale data.
                        k <= k + LW'(1);
                        if (k == '0)
                            acc <= '0;
                        else
                            acc <= acc_sum;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end else begin
                        acc      <= acc_sum;
                        din_c_r  <= acc_sum;
                        addr_c_r <= {i, j};
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end else begin
                        j <= j + LW'(1);
                        if (last_j)
                            i <= i + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl_p.sv
// Self-checking bench for matmul_ctrl_p at N=4: directed scenarios plus random
// matrices compared against a plain-arithmetic matrix product.
module tb_matmul_ctrl_p;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 18;
    localparam int LAT = N*N*(N+2) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          signed_mode;
    logic          busy;
    logic          done;
    logic          nce_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] do_a;
    logic          nce_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] do_b;
    logic          nce_c;
    logic          nwrt_c;
    logic [AW-1:0] addr_c;
    logic [CW-1:0] din_c;

    matmul_ctrl_p #(.N(N), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .nce_a(nce_a), .addr_a(addr_a), .do_a(do_a),
        .nce_b(nce_b), .addr_b(addr_b), .do_b(do_b),
        .nce_c(nce_c), .nwrt_c(nwrt_c), .addr_c(addr_c), .din_c(din_c)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_a [N*N];
    logic [DW-1:0] mem_b [N*N];
    logic [CW-1:0] mem_c [N*N];

    // Register-file read model: data appears the cycle after the address.
    always @(posedge clk) begin
        if (!nce_a) do_a <= mem_a[addr_a];
        if (!nce_b) do_b <= mem_b[addr_b];
    end

    int errors = 0;
    int checks = 0;
    int done_cyc, done_cnt, busy_cnt, first_busy, busy_fall;
    logic [AW-1:0] wr_addrs [$];

    function automatic logic [CW-1:0] ref_c(input int r, input int c, input bit s);
        longint sum;
        longint av;
        longint bv;
        logic [63:0] u;
        sum = 0;
        for (int kk = 0; kk < N; kk++) begin
            av = longint'(mem_a[r*N+kk]);
            bv = longint'(mem_b[kk*N+c]);
            if (s && av >= 128) av = av - 256;
            if (s && bv >= 128) bv = bv - 256;
            sum = sum + av * bv;
        end
        u = sum;
        return u[CW-1:0];
    endfunction

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int w = 0; w < N*N; w++) begin
            mem_a[w] = av;
            mem_b[w] = bv;
        end
    endtask

    task automatic fill_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mem_a[r*N+c] = (r == c) ? 8'd1 : 8'd0;
                mem_b[r*N+c] = DW'(4*r + c);
            end
    endtask

    // Starts an operation at cycle 0 and observes every cycle up to the budget.
    // ab: abort cycle (0 = together with start, -1 = none); p1/p2: extra start pulses.
    task automatic run_op(input bit sm, input int ab, input int p1, input int p2,
                          input int budget);
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; first_busy = -1; busy_fall = -1;
        wr_addrs.delete();
        for (int w = 0; w < N*N; w++) mem_c[w] = 'x;
        @(negedge clk);
        start = 1'b1;
        abort = (ab == 0);
        signed_mode = sm;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
            end else if (first_busy >= 0 && busy_fall < 0) begin
                busy_fall = c;
            end
            if (nce_c === 1'b0 && nwrt_c === 1'b0) begin
                mem_c[addr_c] = din_c;
                wr_addrs.push_back(addr_c);
            end
            start = (c == p1 || c == p2);
            abort = (c == ab);
            signed_mode = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({nce_a, nce_b, nce_c, nwrt_c} !== 4'b1111) begin errors++; $display("FAIL reset_strobes: got %b want 1111", {nce_a, nce_b, nce_c, nwrt_c}); end
        checks++; if ({addr_a, addr_b, addr_c} !== '0) begin errors++; $display("FAIL reset_addr: got %h/%h/%h want 0", addr_a, addr_b, addr_c); end
        checks++; if (din_c !== '0) begin errors++; $display("FAIL reset_din: got %h want 0", din_c); end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        fill_identity();
        run_op(1'b0, -1, -1, -1, LAT + 3);
        checks++; if (done_cyc !== LAT) begin errors++; $display("FAIL ident_done_cycle: got %0d want %0d", done_cyc, LAT); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ident_done_count: got %0d want 1", done_cnt); end
        checks++; if (first_busy !== 1) begin errors++; $display("FAIL ident_busy_rise: got %0d want 1", first_busy); end
        checks++; if (busy_cnt !== LAT - 1) begin errors++; $display("FAIL ident_busy_len: got %0d want %0d", busy_cnt, LAT - 1); end
        checks++; if (wr_addrs.size() !== N*N) begin errors++; $display("FAIL ident_strobes: got %0d want %0d", wr_addrs.size(), N*N); end
        for (int w = 0; w < wr_addrs.size(); w++) begin
            checks++; if (wr_addrs[w] !== AW'(w)) begin errors++; $display("FAIL ident_addr_order[%0d]: got %0d want %0d", w, wr_addrs[w], w); end
        end
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== CW'(w)) begin errors++; $display("FAIL ident_c[%0d]: got %h want %h", w, mem_c[w], w); end
        end
    endtask

    task automatic test_unsigned_max();
        fill_const(8'd255, 8'd255);
        run_op(1'b0, -1, -1, -1, LAT + 1);
        checks++; if (done_cyc !== LAT) begin errors++; $display("FAIL umax_done_cycle: got %0d want %0d", done_cyc, LAT); end
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== 18'h3F804) begin errors++; $display("FAIL umax_c[%0d]: got %h want 3f804", w, mem_c[w]); end
        end
    endtask

    task automatic test_signed();
        fill_const(8'h80, 8'h7F);
        run_op(1'b1, -1, -1, -1, LAT + 1);
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== 18'h30200) begin errors++; $display("FAIL sgn_neg_c[%0d]: got %h want 30200", w, mem_c[w]); end
        end
        fill_const(8'h80, 8'h80);
        run_op(1'b1, -1, -1, -1, LAT + 1);
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== 18'h10000) begin errors++; $display("FAIL sgn_pos_c[%0d]: got %h want 10000", w, mem_c[w]); end
        end
    endtask

    task automatic test_restart_ignored();
        fill_identity();
        run_op(1'b0, -1, 10, 50, LAT + 5);
        checks++; if (done_cyc !== LAT) begin errors++; $display("FAIL restart_done_cycle: got %0d want %0d", done_cyc, LAT); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== CW'(w)) begin errors++; $display("FAIL restart_c[%0d]: got %h want %h", w, mem_c[w], w); end
        end
    endtask

    task automatic test_abort();
        fill_identity();
        run_op(1'b0, 20, -1, -1, 40);
        checks++; if (busy_fall !== 21) begin errors++; $display("FAIL abort_busy_fall: got %0d want 21", busy_fall); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done_count: got %0d want 0", done_cnt); end
        checks++; if (wr_addrs.size() !== 3) begin errors++; $display("FAIL abort_strobes: got %0d want 3", wr_addrs.size()); end
        for (int w = 0; w < 3; w++) begin
            checks++; if (mem_c[w] !== CW'(w)) begin errors++; $display("FAIL abort_c[%0d]: got %h want %h", w, mem_c[w], w); end
        end
        // abort together with start in IDLE: start must win.
        run_op(1'b0, 0, -1, -1, LAT + 1);
        checks++; if (done_cyc !== LAT) begin errors++; $display("FAIL abort_restart_done: got %0d want %0d", done_cyc, LAT); end
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== CW'(w)) begin errors++; $display("FAIL abort_restart_c[%0d]: got %h want %h", w, mem_c[w], w); end
        end
    endtask

    task automatic test_reset_mid();
        fill_identity();
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_busy_done: got %b want 00", {busy, done}); end
        checks++; if ({nce_a, nce_b, nce_c, nwrt_c} !== 4'b1111) begin errors++; $display("FAIL rstmid_strobes: got %b want 1111", {nce_a, nce_b, nce_c, nwrt_c}); end
        checks++; if ({addr_a, addr_b, addr_c} !== '0) begin errors++; $display("FAIL rstmid_addr: got %h/%h/%h want 0", addr_a, addr_b, addr_c); end
        checks++; if (din_c !== '0) begin errors++; $display("FAIL rstmid_din: got %h want 0", din_c); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({nce_c, nwrt_c, busy} !== 3'b110) begin errors++; $display("FAIL rstmid_hold[%0d]: got %b want 110", c, {nce_c, nwrt_c, busy}); end
        end
        rst = 1'b0;
        run_op(1'b0, -1, -1, -1, LAT + 1);
        checks++; if (done_cyc !== LAT) begin errors++; $display("FAIL rstmid_done_cycle: got %0d want %0d", done_cyc, LAT); end
        for (int w = 0; w < N*N; w++) begin
            checks++; if (mem_c[w] !== CW'(w)) begin errors++; $display("FAIL rstmid_c[%0d]: got %h want %h", w, mem_c[w], w); end
        end
    endtask

    task automatic test_random();
        bit sm;
        logic [CW-1:0] exp_c;
        for (int it = 0; it < 4; it++) begin
            sm = 1'($urandom_range(0, 1));
            for (int w = 0; w < N*N; w++) begin
                mem_a[w] = DW'($urandom);
                mem_b[w] = DW'($urandom);
            end
            run_op(sm, -1, -1, -1, LAT + 1);
            checks++; if (done_cyc !== LAT) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, done_cyc, LAT); end
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    exp_c = ref_c(r, c, sm);
                    checks++; if (mem_c[r*N+c] !== exp_c) begin errors++; $display("FAIL rand%0d_c[%0d][%0d] s=%0d: got %h want %h", it, r, c, sm, mem_c[r*N+c], exp_c); end
                end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_identity();
        test_unsigned_max();
        test_signed();
        test_restart_ignored();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
